// File: rtl/control_unit.sv
// control_unit
//   Microcoded-style Moore controller for a small 16-bit bus-based datapath.
//   It walks fetch, decode and execute sequences for ALU, LD, ST, BZ and HALT
//   instructions and drives the datapath load/tristate/select strobes.
//
//   Memory handshake: mem_rd/mem_wr are held while mem_ready is low. A read
//   loads the MDR (lmdr) in the cycle mem_ready is seen. The controller may
//   leave a wait state only in that same cycle. A wait that lasts
//   MEM_TIMEOUT cycles without mem_ready stops the machine in HALT and sets
//   the sticky bus_err flag.
//
// Ports
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   ir[15:0]          : opcode [15:12], rd [11:9], rs1 [8:6], rs2 [5:3]
//   zin               : ALU zero flag, captured into zflag only in E2
//   mem_ready         : memory handshake completion
//   lmar..ldy         : register load enables
//   tt..tmdrext       : bus tristate enables (at most one per cycle)
//   rmdri, rmarx,
//   rdr, wrr          : MDR-from-bus, MAR drives address, reg read, reg write
//   pa, wpa           : register file read / write addresses
//   fnsel             : ALU function (ADD 010, SUB 110, AND 000, OR 001, SLT 111)
//   mem_rd, mem_wr    : memory strobes
//   halted, bus_err   : machine stopped / memory timeout seen
//   illegal           : one-cycle pulse in DEC for an undefined opcode
module control_unit #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        zin,
    input  logic        mem_ready,
    output logic        lmar,
    output logic        lt,
    output logic        lpc,
    output logic        lir,
    output logic        lmdr,
    output logic        ldx,
    output logic        ldy,
    output logic        tt,
    output logic        tpc,
    output logic        tp,
    output logic        t2,
    output logic        tmdr2x,
    output logic        tmdrext,
    output logic        rmdri,
    output logic        rmarx,
    output logic        rdr,
    output logic        wrr,
    output logic [2:0]  pa,
    output logic [2:0]  wpa,
    output logic [2:0]  fnsel,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        halted,
    output logic        bus_err,
    output logic        illegal
);

    typedef enum logic [4:0] {
        RST, F0, F1, F2, F3, F4, F5, F6, DEC,
        E0, E1, E2, E3,
        A0, A1, A2, A3,
        L4, L5, S4, S5,
        B0, B1, B2, B3,
        HALT
    } state_e;

    localparam logic [2:0] FN_ADD = 3'b010;
    localparam logic [2:0] FN_SUB = 3'b110;
    localparam logic [2:0] FN_AND = 3'b000;
    localparam logic [2:0] FN_OR  = 3'b001;
    localparam logic [2:0] FN_SLT = 3'b111;

    // The wait counter holds (cycles already spent in the wait state), so the
    // MEM_TIMEOUT-th cycle is the one where it reads MEM_TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic       zflag_q, zflag_d;
    logic       bus_err_q, bus_err_d;
    logic [7:0] wait_q, wait_d;

    logic [3:0] opcode;
    logic [2:0] rd_f, rs1_f, rs2_f;
    logic       timeout;
    logic       unused_ir_bits;

    assign opcode         = ir[15:12];
    assign rd_f           = ir[11:9];
    assign rs1_f          = ir[8:6];
    assign rs2_f          = ir[5:3];
    assign unused_ir_bits = ^ir[2:0];
    assign timeout        = (wait_q == WAIT_LAST) && !mem_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RST;
            zflag_q   <= 1'b0;
            bus_err_q <= 1'b0;
            wait_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            zflag_q   <= zflag_d;
            bus_err_q <= bus_err_d;
            wait_q    <= wait_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        zflag_d   = zflag_q;
        bus_err_d = bus_err_q;
        unique case (state_q)
            RST: state_d = F0;
            F0:  state_d = F1;
            F1: begin
                if (mem_ready) begin
                    state_d = F2;
                end else if (timeout) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end
            end
            F2:  state_d = F3;
            F3:  state_d = F4;
            F4:  state_d = F5;
            F5:  state_d = F6;
            F6:  state_d = DEC;
            DEC: begin
                unique case (opcode)
                    4'd0, 4'd1, 4'd2, 4'd3, 4'd4: state_d = E0;
                    4'd5, 4'd6:                   state_d = A0;
                    4'd7:                         state_d = zflag_q ? B0 : F0;
                    4'd15:                        state_d = HALT;
                    default:                      state_d = F0;
                endcase
            end
            E0:  state_d = E1;
            E1:  state_d = E2;
            E2: begin
                state_d = E3;
                zflag_d = zin;
            end
            E3:  state_d = F0;
            A0:  state_d = A1;
            A1:  state_d = A2;
            A2:  state_d = A3;
            // ir still holds the instruction, so LD/ST splits after the
            // shared address phase.
            A3:  state_d = (opcode == 4'd6) ? S4 : L4;
            L4: begin
                if (mem_ready) begin
                    state_d = L5;
                end else if (timeout) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end
            end
            L5:  state_d = F0;
            S4:  state_d = S5;
            S5: begin
                if (mem_ready) begin
                    state_d = F0;
                end else if (timeout) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end
            end
            B0:   state_d = B1;
            B1:   state_d = B2;
            B2:   state_d = B3;
            B3:   state_d = F0;
            HALT: state_d = HALT;
            default: state_d = RST;
        endcase

        // Count only while staying in a wait state; any entry starts at zero.
        if ((state_q == F1 || state_q == L4 || state_q == S5) && state_d == state_q) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = 8'd0;
        end
    end

    // Output logic (Moore, except lmdr in read waits qualified by mem_ready)
    always_comb begin
        lmar = 1'b0; lt = 1'b0; lpc = 1'b0; lir = 1'b0;
        lmdr = 1'b0; ldx = 1'b0; ldy = 1'b0;
        tt = 1'b0; tpc = 1'b0; tp = 1'b0; t2 = 1'b0;
        tmdr2x = 1'b0; tmdrext = 1'b0;
        rmdri = 1'b0; rmarx = 1'b0; rdr = 1'b0; wrr = 1'b0;
        pa = 3'd0; wpa = 3'd0; fnsel = 3'd0;
        mem_rd = 1'b0; mem_wr = 1'b0; halted = 1'b0; illegal = 1'b0;
        bus_err = 1'b0;
        unique case (state_q)
            F0:  begin tpc = 1'b1; lmar = 1'b1; end
            F1:  begin rmarx = 1'b1; mem_rd = 1'b1; lmdr = mem_ready; end
            F2:  begin tmdr2x = 1'b1; lir = 1'b1; end
            F3:  begin tpc = 1'b1; ldx = 1'b1; end
            F4:  begin t2 = 1'b1; ldy = 1'b1; end
            F5:  begin fnsel = FN_ADD; lt = 1'b1; end
            F6:  begin tt = 1'b1; lpc = 1'b1; end
            DEC: illegal = !(opcode <= 4'd7 || opcode == 4'd15);
            E0:  begin rdr = 1'b1; pa = rs1_f; tp = 1'b1; ldx = 1'b1; end
            E1:  begin rdr = 1'b1; pa = rs2_f; tp = 1'b1; ldy = 1'b1; end
            E2: begin
                lt = 1'b1;
                unique case (opcode)
                    4'd0:    fnsel = FN_ADD;
                    4'd1:    fnsel = FN_SUB;
                    4'd2:    fnsel = FN_AND;
                    4'd3:    fnsel = FN_OR;
                    4'd4:    fnsel = FN_SLT;
                    default: fnsel = FN_AND;
                endcase
            end
            E3:  begin tt = 1'b1; wrr = 1'b1; wpa = rd_f; end
            A0:  begin rdr = 1'b1; pa = rs1_f; tp = 1'b1; ldx = 1'b1; end
            A1:  begin tmdrext = 1'b1; ldy = 1'b1; end
            A2:  begin fnsel = FN_ADD; lt = 1'b1; end
            A3:  begin tt = 1'b1; lmar = 1'b1; end
            L4:  begin rmarx = 1'b1; mem_rd = 1'b1; lmdr = mem_ready; end
            L5:  begin tmdr2x = 1'b1; wrr = 1'b1; wpa = rd_f; end
            S4:  begin rdr = 1'b1; pa = rd_f; tp = 1'b1; rmdri = 1'b1; lmdr = 1'b1; end
            S5:  begin rmarx = 1'b1; mem_wr = 1'b1; end
            B0:  begin tpc = 1'b1; ldx = 1'b1; end
            B1:  begin tmdrext = 1'b1; ldy = 1'b1; end
            B2:  begin fnsel = FN_ADD; lt = 1'b1; end
            B3:  begin tt = 1'b1; lpc = 1'b1; end
            HALT: begin halted = 1'b1; bus_err = bus_err_q; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit. Each cycle the stimulus names the state the
// controller should be in and the inputs it applies; the expected output word
// for that state is pushed onto a queue and a negedge monitor pops and
// compares it against the DUT outputs.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ir;
    logic        zin;
    logic        mem_ready;
    logic        lmar, lt, lpc, lir, lmdr, ldx, ldy;
    logic        tt, tpc, tp, t2, tmdr2x, tmdrext;
    logic        rmdri, rmarx, rdr, wrr;
    logic [2:0]  pa, wpa, fnsel;
    logic        mem_rd, mem_wr, halted, bus_err, illegal;

    control_unit #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .ir(ir), .zin(zin), .mem_ready(mem_ready),
        .lmar(lmar), .lt(lt), .lpc(lpc), .lir(lir), .lmdr(lmdr), .ldx(ldx), .ldy(ldy),
        .tt(tt), .tpc(tpc), .tp(tp), .t2(t2), .tmdr2x(tmdr2x), .tmdrext(tmdrext),
        .rmdri(rmdri), .rmarx(rmarx), .rdr(rdr), .wrr(wrr),
        .pa(pa), .wpa(wpa), .fnsel(fnsel),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .bus_err(bus_err),
        .illegal(illegal)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    typedef enum {
        T_RST, T_F0, T_F1, T_F2, T_F3, T_F4, T_F5, T_F6, T_DEC,
        T_E0, T_E1, T_E2, T_E3, T_A0, T_A1, T_A2, T_A3,
        T_L4, T_L5, T_S4, T_S5, T_B0, T_B1, T_B2, T_B3, T_HALT
    } tst_e;

    // Output word: {lmar,lt,lpc,lir,lmdr,ldx,ldy, tt,tpc,tp,t2,tmdr2x,tmdrext,
    //               rmdri,rmarx,rdr,wrr, pa, wpa, fnsel,
    //               mem_rd,mem_wr,halted,bus_err,illegal}
    logic [30:0] act;
    assign act = {lmar, lt, lpc, lir, lmdr, ldx, ldy,
                  tt, tpc, tp, t2, tmdr2x, tmdrext,
                  rmdri, rmarx, rdr, wrr, pa, wpa, fnsel,
                  mem_rd, mem_wr, halted, bus_err, illegal};

    logic [30:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    string       scen     = "init";

    // Expected outputs per state, taken from the controller's state table.
    function automatic logic [30:0] exp_out(input tst_e st, input logic [15:0] irv,
                                            input logic rdy, input logic berr);
        logic [6:0] ld;   // lmar lt lpc lir lmdr ldx ldy
        logic [5:0] drv;  // tt tpc tp t2 tmdr2x tmdrext
        logic [3:0] ctl;  // rmdri rmarx rdr wrr
        logic [2:0] pa_e, wpa_e, fn_e;
        logic [4:0] misc; // mem_rd mem_wr halted bus_err illegal
        logic [3:0] op;
        op = irv[15:12];
        ld = '0; drv = '0; ctl = '0; pa_e = '0; wpa_e = '0; fn_e = '0; misc = '0;
        case (st)
            T_F0:  begin drv = 6'b010000; ld = 7'b1000000; end
            T_F1:  begin ctl = 4'b0100; misc = 5'b10000; ld = {4'b0000, rdy, 2'b00}; end
            T_F2:  begin drv = 6'b000010; ld = 7'b0001000; end
            T_F3:  begin drv = 6'b010000; ld = 7'b0000010; end
            T_F4:  begin drv = 6'b000100; ld = 7'b0000001; end
            T_F5:  begin fn_e = 3'b010; ld = 7'b0100000; end
            T_F6:  begin drv = 6'b100000; ld = 7'b0010000; end
            T_DEC: misc = {4'b0000, (op >= 4'd8 && op <= 4'd14)};
            T_E0:  begin ctl = 4'b0010; pa_e = irv[8:6]; drv = 6'b001000; ld = 7'b0000010; end
            T_E1:  begin ctl = 4'b0010; pa_e = irv[5:3]; drv = 6'b001000; ld = 7'b0000001; end
            T_E2: begin
                ld = 7'b0100000;
                case (op)
                    4'd0: fn_e = 3'b010;
                    4'd1: fn_e = 3'b110;
                    4'd2: fn_e = 3'b000;
                    4'd3: fn_e = 3'b001;
                    4'd4: fn_e = 3'b111;
                    default: fn_e = 3'b000;
                endcase
            end
            T_E3:  begin drv = 6'b100000; ctl = 4'b0001; wpa_e = irv[11:9]; end
            T_A0:  begin ctl = 4'b0010; pa_e = irv[8:6]; drv = 6'b001000; ld = 7'b0000010; end
            T_A1:  begin drv = 6'b000001; ld = 7'b0000001; end
            T_A2:  begin fn_e = 3'b010; ld = 7'b0100000; end
            T_A3:  begin drv = 6'b100000; ld = 7'b1000000; end
            T_L4:  begin ctl = 4'b0100; misc = 5'b10000; ld = {4'b0000, rdy, 2'b00}; end
            T_L5:  begin drv = 6'b000010; ctl = 4'b0001; wpa_e = irv[11:9]; end
            T_S4:  begin ctl = 4'b1010; pa_e = irv[11:9]; drv = 6'b001000; ld = 7'b0000100; end
            T_S5:  begin ctl = 4'b0100; misc = 5'b01000; end
            T_B0:  begin drv = 6'b010000; ld = 7'b0000010; end
            T_B1:  begin drv = 6'b000001; ld = 7'b0000001; end
            T_B2:  begin fn_e = 3'b010; ld = 7'b0100000; end
            T_B3:  begin drv = 6'b100000; ld = 7'b0010000; end
            T_HALT: misc = {2'b00, 1'b1, berr, 1'b0};
            default: ;
        endcase
        return {ld, drv, ctl, pa_e, wpa_e, fn_e, misc};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [30:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: actual %b required %b", nm, act, e);
            end
        end
    end

    // Driver tasks: apply inputs for the current cycle, queue the expectation,
    // then move to just after the next rising edge.
    task automatic step(input tst_e st, input logic rdy, input logic rst, input logic berr);
        mem_ready = rdy;
        reset     = rst;
        exp_q.push_back(exp_out(st, ir, rdy, berr));
        name_q.push_back($sformatf("%s/%s", scen, st.name()));
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] instr, input int delay);
        ir = instr;
        step(T_F0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < delay; i++) step(T_F1, 1'b0, 1'b0, 1'b0);
        step(T_F1, 1'b1, 1'b0, 1'b0);
        step(T_F2, 1'b1, 1'b0, 1'b0);
        step(T_F3, 1'b1, 1'b0, 1'b0);
        step(T_F4, 1'b1, 1'b0, 1'b0);
        step(T_F5, 1'b1, 1'b0, 1'b0);
        step(T_F6, 1'b1, 1'b0, 1'b0);
        step(T_DEC, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic alu_exec(input logic z);
        step(T_E0, 1'b1, 1'b0, 1'b0);
        step(T_E1, 1'b1, 1'b0, 1'b0);
        zin = z;
        step(T_E2, 1'b1, 1'b0, 1'b0);
        zin = 1'b0;
        step(T_E3, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic addr_phase();
        step(T_A0, 1'b1, 1'b0, 1'b0);
        step(T_A1, 1'b1, 1'b0, 1'b0);
        step(T_A2, 1'b1, 1'b0, 1'b0);
        step(T_A3, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; ir = 16'h0000; zin = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        scen = "reset";
        step(T_RST, 1'b1, 1'b1, 1'b0);
        step(T_RST, 1'b1, 1'b0, 1'b0);

        // ADD r3,r1,r2: E3 (wrr, wpa=3) is the 12th cycle after release
        scen = "add";     fetch(16'h0650, 0); alu_exec(1'b0);
        // Fetch with mem_ready 3 cycles late, SUB giving zero
        scen = "sub_z";   fetch(16'h1000, 3); alu_exec(1'b1);
        scen = "bz_take"; fetch(16'h7000, 0);
        step(T_B0, 1'b1, 1'b0, 1'b0);
        step(T_B1, 1'b1, 1'b0, 1'b0);
        step(T_B2, 1'b1, 1'b0, 1'b0);
        step(T_B3, 1'b1, 1'b0, 1'b0);
        scen = "sub_nz";  fetch(16'h1000, 0); alu_exec(1'b0);
        scen = "bz_not";  fetch(16'h7000, 0);
        scen = "and";     fetch(16'h2000, 0); alu_exec(1'b0);
        scen = "or";      fetch(16'h3000, 0); alu_exec(1'b0);
        scen = "slt";     fetch(16'h4000, 0); alu_exec(1'b0);

        scen = "ld";      fetch(16'h5A40, 0); addr_phase();
        step(T_L4, 1'b0, 1'b0, 1'b0);
        step(T_L4, 1'b1, 1'b0, 1'b0);
        step(T_L5, 1'b1, 1'b0, 1'b0);

        scen = "st";      fetch(16'h6C80, 0); addr_phase();
        step(T_S4, 1'b1, 1'b0, 1'b0);
        step(T_S5, 1'b0, 1'b0, 1'b0);
        step(T_S5, 1'b0, 1'b0, 1'b0);
        step(T_S5, 1'b1, 1'b0, 1'b0);

        scen = "illegal"; fetch(16'hA000, 0);

        // Reset in the middle of a LD memory wait
        scen = "ld_rst";  fetch(16'h5A40, 0); addr_phase();
        step(T_L4, 1'b0, 1'b0, 1'b0);
        step(T_L4, 1'b0, 1'b1, 1'b0);
        step(T_RST, 1'b0, 1'b0, 1'b0);

        // Store whose memory never answers
        scen = "st_tmo";  fetch(16'h6C80, 0); addr_phase();
        step(T_S4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(T_S5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(T_HALT, 1'b0, 1'b0, 1'b1);
        step(T_HALT, 1'b1, 1'b1, 1'b1);
        step(T_RST, 1'b1, 1'b0, 1'b0);

        scen = "halt";    fetch(16'hF000, 0);
        for (int i = 0; i < 4; i++) step(T_HALT, 1'b1, 1'b0, 1'b0);
        step(T_HALT, 1'b1, 1'b1, 1'b0);
        step(T_RST, 1'b1, 1'b0, 1'b0);

        // Every queued expectation must have been consumed by the monitor
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: actual %0d pending required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
